mem_port: RTL and testbench

- Memory-side port of the multi-cycle core. It sits directly downstream of the control unit's mem_rden/mem_wren strobes.
- Converts each strobe into one word-aligned bus transaction with byte enables, waiting for bus_ack as long as the bus takes.
- For loads it aligns and sign- or zero-extends the returned data.
- Returns a one-cycle done pulse that the control unit uses to advance its cycle counter.

---
 rtl/mem_port_pkg.sv | 41 ++++
 rtl/mem_align.sv | 48 ++++
 rtl/mem_port.sv | 140 ++++++++++++++
 tb/tb_mem_port.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared core definitions for the memory port: access sizes, port FSM states, funct3 codes.
// The misalignment trap is enabled by defining MEM_MISALIGN_TRAP_EN.
package mem_port_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_BU = 3'b100,
    MS_HU = 3'b101
  } memsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memport_state_t;

  // Fetches are always words; undefined data funct3 codes fall back to word.
  function automatic memsize_t decode_size(input logic is_data, input logic [2:0] funct3);
    memsize_t size;
    size = MS_W;
    if (is_data) begin
      case (funct3)
        FUNCT3_B:  size = MS_B;
        FUNCT3_H:  size = MS_H;
        FUNCT3_BU: size = MS_BU;
        FUNCT3_HU: size = MS_HU;
        default:   size = MS_W;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication and load extraction/extension.
// Only the address bits inside the access size pick the lane.
module mem_align
  import mem_port_pkg::*;
(
  input  memsize_t    size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = bus_rdata_i[7:0];
      2'd1:    byte_v = bus_rdata_i[15:8];
      2'd2:    byte_v = bus_rdata_i[23:16];
      default: byte_v = bus_rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  end

  always_comb begin
    be_o        = 4'b1111;
    bus_wdata_o = wdata_i;
    rdata_o     = bus_rdata_i;
    case (size_i)
      MS_B, MS_BU: begin
        be_o        = 4'b0001 << addr_lo_i;
        bus_wdata_o = {4{wdata_i[7:0]}};
        rdata_o     = {{24{byte_v[7] & (size_i == MS_B)}}, byte_v};
      end
      MS_H, MS_HU: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        bus_wdata_o = {2{wdata_i[15:0]}};
        rdata_o     = {{16{half_v[15] & (size_i == MS_H)}}, half_v};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Memory-side port: turns rden/wren strobes into one word-aligned bus transaction with a done pulse.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses without a bus cycle.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rden,
  input  logic              mem_wren,
  input  logic              is_data,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              misaligned,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output memport_state_t    dbg_state
);

  // Bus handshake: bus_req rises the cycle after an accepted strobe and stays high, with
  // we/addr/be/wdata stable, through the cycle bus_ack is high; that edge completes the
  // transfer and bus_rdata is sampled in the same cycle. bus_ack outside REQ is ignored.

  memport_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  memsize_t          size_q, size_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  memsize_t          size_in;
  logic [3:0]        be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] ext_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
  logic              trap_in;
`endif

  assign size_in = decode_size(is_data, funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_in = (((size_in == MS_H) || (size_in == MS_HU)) && addr[0]) ||
                   ((size_in == MS_W) && (addr[1:0] != 2'b00));
`endif

  mem_align u_align (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .bus_rdata_i (bus_rdata),
    .be_o        (be),
    .bus_wdata_o (lane_wdata),
    .rdata_o     (ext_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_rden || mem_wren) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size_in;
          we_d    = mem_wren;
          state_d = REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d   = trap_in;
          if (trap_in) state_d = RESP;
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          if (!we_q) rdata_d = ext_rdata;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MS_W;
      we_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus_req   = (state_q == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be : 4'b0000;
  assign bus_wdata = bus_req ? lane_wdata : '0;
  assign done      = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = done & mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: per-cycle expectations from an arithmetic lane model, rdata via a scoreboard queue.
// Trap expectations follow MEM_MISALIGN_TRAP_EN when it is defined.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rden, mem_wren, is_data;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        done, busy, misaligned;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] hold;
  logic        chk_en;
  logic        exp_req, exp_we, exp_done, exp_busy, exp_mis;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  always #5 clk = ~clk;

  mem_port dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .is_data    (is_data),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .busy       (busy),
    .misaligned (misaligned),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access width in bytes.
  function automatic int m_bytes(input logic isd, input logic [2:0] f3);
    if (!isd) return 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input int nb, input logic [31:0] a);
    if (nb == 1) return 4'(1 << (a % 4));
    if (nb == 2) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] wd);
    if (nb == 1) return wd[7:0] * 32'h0101_0101;
    if (nb == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input int nb, input bit uns, input logic [31:0] a,
                                          input logic [31:0] rw);
    logic [31:0] v;
    if (nb == 4) return rw;
    v = rw >> (8 * ((nb == 1) ? (a % 4) : (a & 2)));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit m_trap(input int nb, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`else
    return (nb == 0) && (a == 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic idle_exp();
    exp_req  = 1'b0;
    exp_done = 1'b0;
    exp_busy = 1'b0;
    exp_mis  = 1'b0;
  endtask

  // One complete transaction; lat is the number of cycles from strobe to the observed done.
  task automatic run_txn(input logic rd, input logic wr, input logic isd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                         input int waits, input bit poke,
                         output int lat, output logic [3:0] seen_be, output logic [31:0] seen_wd);
    int nb;
    bit uns, trap;
    int cyc;
    nb   = m_bytes(isd, f3);
    uns  = isd && f3[2];
    trap = m_trap(nb, a);
    lat = 0; cyc = 0; seen_be = 4'h0; seen_wd = 32'h0;
    @(posedge clk); #1;
    mem_rden = rd; mem_wren = wr; is_data = isd; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'b0; bus_rdata = $urandom;
    idle_exp();
    exp_q.push_back((wr || trap) ? hold : m_rdata(nb, uns, a, rw));
    @(negedge clk);
    if (!trap) begin
      for (int i = 0; i <= waits; i++) begin
        @(posedge clk); #1;
        mem_rden = poke & 1'($urandom_range(0, 1));
        mem_wren = poke & 1'($urandom_range(0, 1));
        if (poke) begin
          addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
          is_data = 1'($urandom_range(0, 1));
        end
        bus_ack   = (i == waits);
        bus_rdata = (i == waits) ? rw : $urandom;
        exp_req = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_mis = 1'b0;
        exp_we = wr; exp_addr = {a[31:2], 2'b00};
        exp_be = m_be(nb, a); exp_wdata = m_wdata(nb, wd);
        @(negedge clk);
        cyc++;
        if (done && lat == 0) lat = cyc;
        seen_be = bus_be; seen_wd = bus_wdata;
      end
    end
    @(posedge clk); #1;
    mem_rden = poke; mem_wren = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
    exp_req = 1'b0; exp_done = 1'b1; exp_busy = 1'b1; exp_mis = trap;
    @(negedge clk);
    cyc++;
    if (done && lat == 0) lat = cyc;
    @(posedge clk); #1;
    mem_rden = 1'b0; mem_wren = 1'b0;
    idle_exp();
    @(negedge clk);
  endtask

  // Compare process: every cycle once out of reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_req", bus_req, exp_req);
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("misaligned", misaligned, exp_mis);
      if (exp_req) begin
        chk("bus_we", bus_we, exp_we);
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_be", bus_be, exp_be);
        chk("bus_wdata", bus_wdata, exp_wdata);
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_scoreboard: got done=1 want no pending transaction at %0t", $time);
        end else begin
          hold = exp_q.pop_front();
        end
      end
      chk("rdata", rdata, hold);
      if (rst) begin
        hold = 32'h0;
        exp_q.delete();
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish want finish by 300000");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [3:0] sbe;
    logic [31:0] swd;
    rst = 1'b1; mem_rden = 1'b0; mem_wren = 1'b0; is_data = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    hold = 32'h0; chk_en = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
    idle_exp();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'h0);
    chk("reset_bus_req", bus_req, 1'b0);

    // Fetch, ack in the first REQ cycle.
    run_txn(1, 0, 0, 3'b010, 32'h104, 32'h0, 32'h0050_0093, 0, 0, lat, sbe, swd);
    chk("fetch_lat", lat, 2);
    chk("fetch_be", sbe, 4'b1111);
    chk("fetch_rdata", rdata, 32'h0050_0093);

    // LB with sign extension, three wait states.
    run_txn(1, 0, 1, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 3, 0, lat, sbe, swd);
    chk("lb_lat", lat, 5);
    chk("lb_be", sbe, 4'b1000);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);

    // LHU upper half.
    run_txn(1, 0, 1, 3'b101, 32'h202, 32'h0, 32'h9ABC_5678, 1, 0, lat, sbe, swd);
    chk("lhu_be", sbe, 4'b1100);
    chk("lhu_rdata", rdata, 32'h0000_9ABC);

    // SB: lane replication, rdata untouched.
    run_txn(0, 1, 1, 3'b000, 32'h301, 32'h1234_56A5, 32'hDEAD_BEEF, 0, 0, lat, sbe, swd);
    chk("sb_be", sbe, 4'b0010);
    chk("sb_wdata", swd, 32'hA5A5_A5A5);
    chk("sb_rdata_held", rdata, 32'h0000_9ABC);

    // Both strobes: write wins (SH).
    run_txn(1, 1, 1, 3'b001, 32'h402, 32'h0000_BEEF, 32'h1111_1111, 2, 0, lat, sbe, swd);
    chk("sh_wdata", swd, 32'hBEEF_BEEF);
    chk("sh_rdata_held", rdata, 32'h0000_9ABC);

    // Strobes during REQ and RESP are ignored.
    run_txn(1, 0, 1, 3'b010, 32'h500, 32'h0, 32'hCAFE_F00D, 2, 1, lat, sbe, swd);
    chk("poke_lat", lat, 4);
    chk("poke_rdata", rdata, 32'hCAFE_F00D);

    // LW at a misaligned address.
    run_txn(1, 0, 1, 3'b010, 32'h102, 32'h0, 32'h7654_3210, 0, 0, lat, sbe, swd);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_rdata", rdata, 32'hCAFE_F00D);
`else
    chk("lw_mis_lat", lat, 2);
    chk("lw_mis_rdata", rdata, 32'h7654_3210);
`endif

    // Reset in the second wait cycle; late ack ignored.
    @(posedge clk); #1;
    mem_rden = 1'b1; is_data = 1'b1; funct3 = 3'b010; addr = 32'h400; wdata = 32'h55;
    idle_exp();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      mem_rden = 1'b0;
      rst = (i == 1);
      exp_req = 1'b1; exp_busy = 1'b1; exp_we = 1'b0; exp_addr = 32'h400;
      exp_be = 4'hF; exp_wdata = 32'h55;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      idle_exp();
      bus_ack = 1'b1; bus_rdata = $urandom;
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_req", bus_req, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic rd, wr, isd;
      logic [2:0] f3;
      logic [31:0] a;
      int w;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      isd = ($urandom_range(0, 3) != 0);
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      w   = $urandom_range(0, 3);
      run_txn(rd, wr, isd, f3, a, $urandom, $urandom, w, bit'($urandom_range(0, 1)), lat, sbe, swd);
      chk("rand_lat", lat, m_trap(m_bytes(isd, f3), a) ? 1 : w + 2);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
